// File: rtl/mod_pipe_stage.sv
// Pipeline register slice with a valid/ready handshake, an optional 2-entry skid buffer,
// stall and flush. The payload is split into a control field, which reads as zero whenever
// the output is invalid, and a data field, which keeps its last value.
module mod_pipe_stage #(
    parameter int unsigned CTRL_W  = 7,
    parameter int unsigned DATA_W  = 101,
    parameter bit          SKID_EN = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [CTRL_W-1:0] in_ctrl_i,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [CTRL_W-1:0] out_ctrl_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic [1:0]        occupancy_o
);

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StFull  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;

    logic in_fire;
    logic out_fire;
    logic out_valid;

    assign out_valid = (state_q != StEmpty);

    // Upstream ready; the skid variant only looks at local state so out_ready_i never
    // reaches in_ready_o combinationally.
    always_comb begin
        in_ready_o = 1'b0;
        if (SKID_EN) begin
            in_ready_o = (state_q != StFull) && !stall_i && !flush_i;
        end else begin
            in_ready_o = ((state_q == StEmpty) || out_ready_i) && !stall_i && !flush_i;
        end
    end

    assign in_fire  = in_valid_i && in_ready_o;
    assign out_fire = out_valid && out_ready_i && !stall_i && !flush_i;

    // Next-state and register update selection; stall needs no branch because it
    // suppresses both fires, which leaves every register holding.
    always_comb begin
        state_d     = state_q;
        main_ctrl_d = main_ctrl_q;
        main_data_d = main_data_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_data_d = skid_data_q;

        if (flush_i) begin
            // Entries are discarded; data is left alone so out_data_o keeps its value.
            state_d = StEmpty;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (in_fire) begin
                        state_d     = StOne;
                        main_ctrl_d = in_ctrl_i;
                        main_data_d = in_data_i;
                    end
                end
                StOne: begin
                    if (in_fire && out_fire) begin
                        main_ctrl_d = in_ctrl_i;
                        main_data_d = in_data_i;
                    end else if (in_fire) begin
                        if (SKID_EN) begin
                            state_d     = StFull;
                            skid_ctrl_d = in_ctrl_i;
                            skid_data_d = in_data_i;
                        end else begin
                            // Cannot occur without a skid buffer: in_fire implies out_fire.
                            main_ctrl_d = in_ctrl_i;
                            main_data_d = in_data_i;
                        end
                    end else if (out_fire) begin
                        state_d = StEmpty;
                    end
                end
                StFull: begin
                    // in_ready_o is low here, so only a drain can happen.
                    if (out_fire) begin
                        state_d     = StOne;
                        main_ctrl_d = skid_ctrl_q;
                        main_data_d = skid_data_q;
                    end
                end
                default: begin
                    state_d = StEmpty;
                end
            endcase
        end
    end

    // State and payload registers with asynchronous clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StEmpty;
            main_ctrl_q <= '0;
            main_data_q <= '0;
            skid_ctrl_q <= '0;
            skid_data_q <= '0;
        end else begin
            state_q     <= state_d;
            main_ctrl_q <= main_ctrl_d;
            main_data_q <= main_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            skid_data_q <= skid_data_d;
        end
    end

    // Output decode: control masked to a bubble when empty, occupancy from state.
    always_comb begin
        out_valid_o = out_valid;
        out_ctrl_o  = out_valid ? main_ctrl_q : '0;
        out_data_o  = main_data_q;
        unique case (state_q)
            StOne:   occupancy_o = 2'd1;
            StFull:  occupancy_o = 2'd2;
            default: occupancy_o = 2'd0;
        endcase
    end

`ifndef SYNTHESIS
    // A presented entry stays put until it is taken or flushed.
    a_hold_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
        (out_valid_o && !out_fire && !flush_i)
            |=> (out_valid_o && $stable(out_data_o) && $stable(out_ctrl_o)));

    // Bubbles never carry control bits.
    a_bubble_zero : assert property (@(posedge clk_i) disable iff (!rst_ni)
        !out_valid_o |-> (out_ctrl_o == '0));

    // Without a skid buffer the second entry slot is never used.
    a_no_full : assert property (@(posedge clk_i) disable iff (!rst_ni)
        !SKID_EN |-> (state_q != StFull));
`endif

endmodule

// File: tb/tb_mod_pipe_stage.sv
// Self-checking bench for mod_pipe_stage (default parameters, skid buffer enabled).
module tb_mod_pipe_stage;

    logic         clk_i;
    logic         rst_ni;
    logic         stall_i;
    logic         flush_i;
    logic         in_valid_i;
    logic         in_ready_o;
    logic [6:0]   in_ctrl_i;
    logic [100:0] in_data_i;
    logic         out_valid_o;
    logic         out_ready_i;
    logic [6:0]   out_ctrl_o;
    logic [100:0] out_data_o;
    logic [1:0]   occupancy_o;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [6:0]   c;
        logic [100:0] d;
    } ent_t;

    ent_t sb[$];

    typedef struct {
        logic         vin;
        logic         ordy;
        logic         stall;
        logic         flush;
        logic [6:0]   ctrl;
        logic [100:0] data;
        logic         exp_rdy;
        logic [1:0]   exp_occ;
        logic         exp_valid;
        logic [6:0]   exp_ctrl;
    } vec_t;

    vec_t vecs[14];

    mod_pipe_stage #(
        .CTRL_W (7),
        .DATA_W (101),
        .SKID_EN(1'b1)
    ) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .stall_i    (stall_i),
        .flush_i    (flush_i),
        .in_valid_i (in_valid_i),
        .in_ready_o (in_ready_o),
        .in_ctrl_i  (in_ctrl_i),
        .in_data_i  (in_data_i),
        .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i),
        .out_ctrl_o (out_ctrl_o),
        .out_data_o (out_data_o),
        .occupancy_o(occupancy_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // One cycle starting from a falling edge: drive, settle, score handshakes, clock,
    // return at the next falling edge with the post-edge outputs stable.
    task automatic step(input logic vin, input logic ordy, input logic st, input logic fl,
                        input logic [6:0] c, input logic [100:0] d, output logic rdy);
        logic ifire;
        logic ofire;
        ent_t e;
        in_valid_i  = vin;
        out_ready_i = ordy;
        stall_i     = st;
        flush_i     = fl;
        in_ctrl_i   = c;
        in_data_i   = d;
        #1;
        rdy   = in_ready_o;
        ifire = vin && in_ready_o;
        ofire = out_valid_o && ordy && !st && !fl;
        if (ofire) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 128'(out_ctrl_o), 128'h7f);
            end else begin
                e = sb.pop_front();
                chk("sb_ctrl", 128'(out_ctrl_o), 128'(e.c));
                chk("sb_data", 128'(out_data_o), 128'(e.d));
            end
        end
        if (ifire) sb.push_back('{c: c, d: d});
        @(posedge clk_i);
        if (fl) sb.delete();
        @(negedge clk_i);
    endtask

    initial begin
        logic rdy;

        vecs[0]  = '{1, 0, 0, 0, 7'h01, 101'hA0, 1, 2'd1, 1, 7'h01};
        vecs[1]  = '{1, 0, 0, 0, 7'h02, 101'hB0, 1, 2'd2, 1, 7'h01};
        vecs[2]  = '{1, 0, 0, 0, 7'h03, 101'hC0, 0, 2'd2, 1, 7'h01};
        vecs[3]  = '{0, 1, 0, 0, 7'h00, 101'h0,  0, 2'd1, 1, 7'h02};
        vecs[4]  = '{0, 1, 0, 0, 7'h00, 101'h0,  1, 2'd0, 0, 7'h00};
        vecs[5]  = '{1, 0, 0, 0, 7'h11, 101'h1A, 1, 2'd1, 1, 7'h11};
        vecs[6]  = '{1, 0, 0, 0, 7'h12, 101'h1B, 1, 2'd2, 1, 7'h11};
        vecs[7]  = '{1, 1, 0, 1, 7'h13, 101'h1C, 0, 2'd0, 0, 7'h00};
        vecs[8]  = '{0, 1, 0, 0, 7'h00, 101'h0,  1, 2'd0, 0, 7'h00};
        vecs[9]  = '{1, 0, 0, 0, 7'h21, 101'h2A, 1, 2'd1, 1, 7'h21};
        vecs[10] = '{1, 1, 1, 0, 7'h22, 101'h2B, 0, 2'd1, 1, 7'h21};
        vecs[11] = '{1, 1, 1, 0, 7'h22, 101'h2B, 0, 2'd1, 1, 7'h21};
        vecs[12] = '{1, 1, 1, 0, 7'h22, 101'h2B, 0, 2'd1, 1, 7'h21};
        vecs[13] = '{0, 1, 0, 0, 7'h00, 101'h0,  1, 2'd0, 0, 7'h00};

        rst_ni      = 1'b0;
        stall_i     = 1'b0;
        flush_i     = 1'b0;
        in_valid_i  = 1'b0;
        out_ready_i = 1'b0;
        in_ctrl_i   = '0;
        in_data_i   = '0;
        #1;
        chk("rst_valid", 128'(out_valid_o), 128'd0);
        chk("rst_ctrl", 128'(out_ctrl_o), 128'd0);
        chk("rst_data", 128'(out_data_o), 128'd0);
        chk("rst_occ", 128'(occupancy_o), 128'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // First transfer: one-cycle latency, identical payload.
        step(1, 1, 0, 0, 7'h15, 101'h1234, rdy);
        chk("t1_rdy", 128'(rdy), 128'd1);
        chk("t1_valid", 128'(out_valid_o), 128'd1);
        chk("t1_ctrl", 128'(out_ctrl_o), 128'h15);
        chk("t1_data", 128'(out_data_o), 128'h1234);
        chk("t1_occ", 128'(occupancy_o), 128'd1);

        // Back-to-back stream with no bubbles.
        for (int i = 0; i < 10; i++) begin
            step(1, 1, 0, 0, 7'(i), 101'(i + 100), rdy);
            chk("stream_rdy", 128'(rdy), 128'd1);
            chk("stream_valid", 128'(out_valid_o), 128'd1);
            chk("stream_ctrl", 128'(out_ctrl_o), 128'(i));
        end
        step(0, 1, 0, 0, 7'h0, 101'h0, rdy);
        chk("drain_valid", 128'(out_valid_o), 128'd0);
        chk("drain_ctrl", 128'(out_ctrl_o), 128'd0);
        chk("drain_data_hold", 128'(out_data_o), 128'd109);
        chk("drain_occ", 128'(occupancy_o), 128'd0);

        // Skid fill/drain, flush while full, stall while holding.
        for (int i = 0; i < 14; i++) begin
            step(vecs[i].vin, vecs[i].ordy, vecs[i].stall, vecs[i].flush,
                 vecs[i].ctrl, vecs[i].data, rdy);
            chk($sformatf("vec%0d_rdy", i), 128'(rdy), 128'(vecs[i].exp_rdy));
            chk($sformatf("vec%0d_occ", i), 128'(occupancy_o), 128'(vecs[i].exp_occ));
            chk($sformatf("vec%0d_valid", i), 128'(out_valid_o), 128'(vecs[i].exp_valid));
            chk($sformatf("vec%0d_ctrl", i), 128'(out_ctrl_o), 128'(vecs[i].exp_ctrl));
            if (i >= 10 && i <= 12) begin
                chk($sformatf("vec%0d_stall_data", i), 128'(out_data_o), 128'h2A);
            end
        end

        // Asynchronous reset while full, observed before the next rising edge.
        step(1, 0, 0, 0, 7'h31, 101'h310, rdy);
        step(1, 0, 0, 0, 7'h32, 101'h320, rdy);
        chk("ar_occ_full", 128'(occupancy_o), 128'd2);
        in_valid_i = 1'b0;
        #3;
        rst_ni = 1'b0;
        #1;
        chk("ar_valid", 128'(out_valid_o), 128'd0);
        chk("ar_ctrl", 128'(out_ctrl_o), 128'd0);
        chk("ar_data", 128'(out_data_o), 128'd0);
        chk("ar_occ", 128'(occupancy_o), 128'd0);
        sb.delete();
        @(negedge clk_i);
        rst_ni = 1'b1;
        #1;
        chk("ar_rel_rdy", 128'(in_ready_o), 128'd1);
        chk("ar_rel_occ", 128'(occupancy_o), 128'd0);
        chk("ar_rel_valid", 128'(out_valid_o), 128'd0);
        @(negedge clk_i);

        // Entries after reset still flow normally.
        step(1, 0, 0, 0, 7'h41, 101'h410, rdy);
        step(0, 1, 0, 0, 7'h00, 101'h0, rdy);
        chk("sb_empty", 128'(sb.size()), 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
